// File: rtl/ega_pkg.sv
// ega_pkg: shared constants, enums and helpers for the EGA graphics controller
package ega_pkg;
  typedef enum logic [1:0] {ALU_PASS, ALU_AND, ALU_OR, ALU_XOR} alu_e;
  typedef enum logic [1:0] {WM0, WM1, WM2, WM3} wrMode_e;
  typedef enum logic {RM0, RM1} rdMode_e;
  typedef enum logic [1:0] {IDLE, RD_ADDR, RD_CAP} rdState_e;
  localparam logic [11:0] PORT_SEQ_IDX = 12'h3C4;
  localparam logic [11:0] PORT_SEQ_DAT = 12'h3C5;
  localparam logic [11:0] PORT_GC_IDX = 12'h3CE;
  localparam logic [11:0] PORT_GC_DAT = 12'h3CF;
  localparam logic [7:0] SEQ_MAPMASK = 8'd2;
  localparam logic [7:0] GC_SR = 8'd0;
  localparam logic [7:0] GC_ESR = 8'd1;
  localparam logic [7:0] GC_CMP = 8'd2;
  localparam logic [7:0] GC_ROT = 8'd3;
  localparam logic [7:0] GC_RMAP = 8'd4;
  localparam logic [7:0] GC_MODE = 8'd5;
  localparam logic [7:0] GC_DC = 8'd7;
  localparam logic [7:0] GC_MASK = 8'd8;
  function automatic logic [7:0] rotr8(input logic [7:0] d, input logic [2:0] r);
    return (d >> r) | (d << (4'd8 - {1'b0, r}));
  endfunction
endpackage

// File: rtl/video_gc_ega_plane.sv
// video_gc_ega_plane: per-plane write source select, ALU and bit mask
module video_gc_ega_plane
  import ega_pkg::*;
(
  input  logic [1:0] iWrMode,
  input  logic [1:0] iAlu,
  input  logic [7:0] iRotData,
  input  logic [7:0] iBitMask,
  input  logic [7:0] iLatch,
  input  logic       iSrEn,
  input  logic       iSrBit,
  input  logic       iWrBit,
  output logic [7:0] oData
);
  logic [7:0] src, alu;
  always_comb begin
    src = iWrMode == WM2 ? {8{iWrBit}} : iSrEn ? {8{iSrBit}} : iRotData;
    alu = iAlu == ALU_AND ? src & iLatch :
          iAlu == ALU_OR  ? src | iLatch :
          iAlu == ALU_XOR ? src ^ iLatch : src;
    oData = iWrMode == WM1 ? iLatch : (iBitMask & alu) | (~iBitMask & iLatch);
  end
endmodule

// File: rtl/video_gc_ega.sv
// video_gc_ega: EGA/VGA graphics controller datapath between CPU bus and planar VRAM
// Optional register readback over IO enabled by VIDEO_GC_EGA_RDBACK_EN.
module video_gc_ega
  import ega_pkg::*;
#(
  parameter int PLANES = 4,
  parameter int ADDR_W = 14,
  parameter logic [4:0] WIN_TAG = 5'b10100
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic [19:0]           iAddr,
  input  logic [7:0]            iWrData,
  input  logic                  iWrMem,
  input  logic                  iRdMem,
  input  logic                  iWrIo,
  input  logic                  iRdIo,
  output logic [7:0]            oRdData,
  output logic                  oSel,
  output logic                  oBusy,
  output logic [ADDR_W-1:0]     oVramAddr,
  output logic [PLANES-1:0]     oVramWr,
  output logic [8*PLANES-1:0]   oVramWrData,
  input  logic [8*PLANES-1:0]   iVramRdData
);
  logic [7:0] seqIdx, gcIdx, bitMask, rotData, rdMode0, rdMode1;
  logic [PLANES-1:0] mapMask;
  logic [3:0] setReset, enSr, colCmp, colDc;
  logic [4:0] rotAlu;
  logic [1:0] readMap, writeMode;
  logic readMode, winHit, memWr, memRd, unused;
  logic [8*PLANES-1:0] latches, planeData;
  logic [11:0] ioPort;
  rdState_e state, stateNext;

  assign ioPort = iAddr[11:0];
  assign winHit = iAddr[19:15] == WIN_TAG;
  assign memWr = iWrMem & winHit & (state == IDLE);
  assign memRd = iRdMem & ~iWrMem & winHit & (state == IDLE);
  assign rotData = rotr8(iWrData, rotAlu[2:0]);
  assign oBusy = state != IDLE;

  for (genvar p = 0; p < PLANES; p++) begin : gPlane
    video_gc_ega_plane uPlane (
      .iWrMode(writeMode), .iAlu(rotAlu[4:3]), .iRotData(rotData), .iBitMask(bitMask),
      .iLatch(latches[8*p +: 8]), .iSrEn(enSr[p]), .iSrBit(setReset[p]), .iWrBit(iWrData[p]),
      .oData(planeData[8*p +: 8])
    );
  end

  always_ff @(posedge iClk) state <= iRst ? IDLE : stateNext;

  always_comb begin
    stateNext = state == IDLE ? (memRd ? RD_ADDR : IDLE) : state == RD_ADDR ? RD_CAP : IDLE;
  end

  // Colour compare: a plane only votes when its don't-care bit is set.
  always_comb begin
    rdMode0 = 8'h00;
    rdMode1 = 8'hFF;
    for (int p = 0; p < PLANES; p++) begin
      if (int'(readMap) == p) rdMode0 = iVramRdData[8*p +: 8];
      if (colDc[p]) rdMode1 &= ~(iVramRdData[8*p +: 8] ^ {8{colCmp[p]}});
    end
  end

`ifdef VIDEO_GC_EGA_RDBACK_EN
  logic [7:0] gcVal, ioRdVal;
  logic ioRdHit;
  always_comb begin
    gcVal = gcIdx == GC_SR ? 8'(setReset) : gcIdx == GC_ESR ? 8'(enSr) :
            gcIdx == GC_CMP ? 8'(colCmp) : gcIdx == GC_ROT ? 8'(rotAlu) :
            gcIdx == GC_RMAP ? 8'(readMap) : gcIdx == GC_MODE ? {4'b0, readMode, 1'b0, writeMode} :
            gcIdx == GC_DC ? 8'(colDc) : gcIdx == GC_MASK ? bitMask : 8'h00;
    ioRdVal = ioPort == PORT_SEQ_IDX ? seqIdx :
              ioPort == PORT_SEQ_DAT ? (seqIdx == SEQ_MAPMASK ? 8'(mapMask) : 8'h00) :
              ioPort == PORT_GC_IDX ? gcIdx : gcVal;
    ioRdHit = iRdIo & (ioPort == PORT_SEQ_IDX || ioPort == PORT_SEQ_DAT ||
                       ioPort == PORT_GC_IDX || ioPort == PORT_GC_DAT);
  end
  assign unused = ^iAddr;
`else
  assign unused = ^{iRdIo, iAddr};
`endif

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oSel <= 1'b0;
      oRdData <= 8'h00;
      oVramWr <= '0;
      oVramWrData <= '0;
      oVramAddr <= '0;
      latches <= '0;
      seqIdx <= 8'h00;
      gcIdx <= 8'h00;
      mapMask <= '1;
      bitMask <= 8'hFF;
      setReset <= 4'h0;
      enSr <= 4'h0;
      colCmp <= 4'h0;
      colDc <= 4'h0;
      rotAlu <= 5'h00;
      readMap <= 2'h0;
      writeMode <= 2'h0;
      readMode <= 1'b0;
    end else begin
      oSel <= 1'b0;
      oVramWr <= '0;
      if (iWrIo && ioPort == PORT_SEQ_IDX) seqIdx <= iWrData;
      if (iWrIo && ioPort == PORT_SEQ_DAT && seqIdx == SEQ_MAPMASK) mapMask <= iWrData[PLANES-1:0];
      if (iWrIo && ioPort == PORT_GC_IDX) gcIdx <= iWrData;
      if (iWrIo && ioPort == PORT_GC_DAT)
        case (gcIdx)
          GC_SR: setReset <= iWrData[3:0];
          GC_ESR: enSr <= iWrData[3:0];
          GC_CMP: colCmp <= iWrData[3:0];
          GC_ROT: rotAlu <= iWrData[4:0];
          GC_RMAP: readMap <= iWrData[1:0];
          GC_MODE: {readMode, writeMode} <= {iWrData[3], iWrData[1:0]};
          GC_DC: colDc <= iWrData[3:0];
          GC_MASK: bitMask <= iWrData;
          default: ;
        endcase
      if (memWr) begin
        oVramAddr <= iAddr[ADDR_W-1:0];
        oVramWr <= mapMask;
        oVramWrData <= planeData;
      end
      if (memRd) oVramAddr <= iAddr[ADDR_W-1:0];
      if (state == RD_CAP) begin
        latches <= iVramRdData;
        oRdData <= readMode ? rdMode1 : rdMode0;
        oSel <= 1'b1;
      end
`ifdef VIDEO_GC_EGA_RDBACK_EN
      else if (ioRdHit) begin
        oRdData <= ioRdVal;
        oSel <= 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_video_gc_ega.sv
// tb_video_gc_ega: directed bench with a behavioural VRAM and register model
module tb_video_gc_ega;
  logic iClk = 1'b0;
  always #5 iClk = ~iClk;
  logic iRst, iWrMem, iRdMem, iWrIo, iRdIo, oSel, oBusy;
  logic [19:0] iAddr;
  logic [7:0] iWrData, oRdData;
  logic [13:0] oVramAddr;
  logic [3:0] oVramWr;
  logic [31:0] oVramWrData, iVramRdData;

  video_gc_ega dut (
    .iClk(iClk), .iRst(iRst), .iAddr(iAddr), .iWrData(iWrData), .iWrMem(iWrMem), .iRdMem(iRdMem),
    .iWrIo(iWrIo), .iRdIo(iRdIo), .oRdData(oRdData), .oSel(oSel), .oBusy(oBusy),
    .oVramAddr(oVramAddr), .oVramWr(oVramWr), .oVramWrData(oVramWrData), .iVramRdData(iVramRdData)
  );

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  // Bench-owned VRAM: synchronous read, one cycle after the address.
  logic ldEn = 1'b0;
  logic [7:0] ldAddr;
  logic [31:0] ldData;
  logic [31:0] vram [256];
  always @(posedge iClk) begin
    if (ldEn) vram[ldAddr] <= ldData;
    else for (int p = 0; p < 4; p++) if (oVramWr[p]) vram[oVramAddr[7:0]][8*p +: 8] <= oVramWrData[8*p +: 8];
    iVramRdData <= vram[oVramAddr[7:0]];
  end

  logic [7:0] gc [9];
  logic [7:0] mm, sIdx, gIdx;
  logic [7:0] lat [4];
  logic [31:0] mem [256];
  int busyEnd;
  logic [7:0] expRd [int];
  logic [3:0] expWr [int];
  logic [31:0] expWd [int];
  logic [13:0] expWa [int];
  bit expBusy [int];
  int checks = 0, errors = 0;
  bit chkEn = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s got %h want %h at cycle %0d", nm, act, ex, cyc);
    end
  endtask

  function automatic void mdlReset();
    foreach (gc[i]) gc[i] = 8'h00;
    gc[8] = 8'hFF;
    mm = 8'h0F;
    sIdx = 8'h00;
    gIdx = 8'h00;
    foreach (lat[i]) lat[i] = 8'h00;
  endfunction

  function automatic logic [7:0] mdlRead(input logic [31:0] w);
    logic [7:0] r;
    if (!gc[5][3]) return gc[4] < 4 ? w[8*gc[4] +: 8] : 8'h00;
    for (int i = 0; i < 8; i++) begin
      r[i] = 1'b1;
      for (int p = 0; p < 4; p++) if (gc[7][p] && w[8*p+i] != gc[2][p]) r[i] = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [31:0] mdlWrite(input logic [7:0] wd);
    logic [15:0] dd;
    logic [7:0] src, a, bm;
    logic [31:0] res;
    dd = {wd, wd} >> gc[3][2:0];
    bm = gc[8];
    for (int p = 0; p < 4; p++) begin
      if (gc[5][1:0] == 2'd1) res[8*p +: 8] = lat[p];
      else begin
        src = gc[5][1:0] == 2'd2 ? (wd[p] ? 8'hFF : 8'h00) : gc[1][p] ? (gc[0][p] ? 8'hFF : 8'h00) : dd[7:0];
        case (gc[3][4:3])
          2'd0: a = src;
          2'd1: a = src & lat[p];
          2'd2: a = src | lat[p];
          default: a = src ^ lat[p];
        endcase
        res[8*p +: 8] = (a & bm) | (lat[p] & ~bm);
      end
    end
    return res;
  endfunction

  function automatic logic [7:0] mdlRdback(input logic [11:0] a);
    if (a == 12'h3C4) return sIdx;
    if (a == 12'h3C5) return sIdx == 8'd2 ? mm : 8'h00;
    if (a == 12'h3CE) return gIdx;
    return gIdx <= 8'd8 ? gc[gIdx[3:0]] : 8'h00;
  endfunction

  always @(negedge iClk) if (chkEn) begin
    chk("sel", oSel, expRd.exists(cyc));
    if (expRd.exists(cyc)) chk("rddata", oRdData, expRd[cyc]);
    chk("busy", oBusy, expBusy.exists(cyc));
    chk("wrstrobe", oVramWr, expWr.exists(cyc) ? expWr[cyc] : 4'h0);
    if (expWr.exists(cyc)) begin
      chk("wrdata", oVramWrData, expWd[cyc]);
      chk("wraddr", oVramAddr, expWa[cyc]);
    end
  end

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] w);
    ldEn = 1'b1; ldAddr = a; ldData = w; mem[a] = w;
    step();
    ldEn = 1'b0;
  endtask

  task automatic ioWr(input logic [11:0] a, input logic [7:0] d);
    iAddr = {8'h00, a}; iWrData = d; iWrIo = 1'b1;
    if (a == 12'h3C4) sIdx = d;
    if (a == 12'h3C5 && sIdx == 8'd2) mm = d & 8'h0F;
    if (a == 12'h3CE) gIdx = d;
    if (a == 12'h3CF)
      case (gIdx)
        8'd0, 8'd1, 8'd2, 8'd7: gc[gIdx[3:0]] = d & 8'h0F;
        8'd3: gc[3] = d & 8'h1F;
        8'd4: gc[4] = d & 8'h03;
        8'd5: gc[5] = d & 8'h0B;
        8'd8: gc[8] = d;
        default: ;
      endcase
    step();
    iWrIo = 1'b0;
  endtask

  task automatic ioRd(input logic [11:0] a);
    iAddr = {8'h00, a}; iRdIo = 1'b1;
`ifdef VIDEO_GC_EGA_RDBACK_EN
    expRd[cyc+1] = mdlRdback(a);
`endif
    step();
    iRdIo = 1'b0;
  endtask

  task automatic memRead(input logic [19:0] a);
    logic [31:0] w;
    iAddr = a; iRdMem = 1'b1;
    if (a[19:15] == 5'b10100 && cyc > busyEnd) begin
      w = mem[a[7:0]];
      expRd[cyc+3] = mdlRead(w);
      expBusy[cyc+1] = 1'b1;
      expBusy[cyc+2] = 1'b1;
      busyEnd = cyc + 2;
      for (int p = 0; p < 4; p++) lat[p] = w[8*p +: 8];
    end
    step();
    iRdMem = 1'b0;
  endtask

  task automatic memWrite(input logic [19:0] a, input logic [7:0] d, input bit alsoRd);
    logic [31:0] wd;
    iAddr = a; iWrData = d; iWrMem = 1'b1; iRdMem = alsoRd;
    if (a[19:15] == 5'b10100 && cyc > busyEnd) begin
      wd = mdlWrite(d);
      expWr[cyc+1] = mm[3:0];
      expWd[cyc+1] = wd;
      expWa[cyc+1] = a[13:0];
      for (int p = 0; p < 4; p++) if (mm[p]) mem[a[7:0]][8*p +: 8] = wd[8*p +: 8];
    end
    step();
    iWrMem = 1'b0; iRdMem = 1'b0;
  endtask

  task automatic resetCyc(input int n);
    int r;
    r = cyc;
    for (int k = r + 1; k < r + 8; k++) begin
      if (expRd.exists(k)) expRd.delete(k);
      if (expBusy.exists(k)) expBusy.delete(k);
      if (expWr.exists(k)) expWr.delete(k);
    end
    mdlReset();
    busyEnd = r;
    iRst = 1'b1;
    repeat (n) step();
    iRst = 1'b0;
  endtask

  task automatic waitSel(input string nm, input logic [7:0] ex);
    bit got;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge iClk);
      if (oSel) begin got = 1; chk(nm, oRdData, ex); end
    end
    if (!got) chk({nm, "_timeout"}, 0, 1);
    step();
  endtask

  task automatic waitWr(input string nm, input logic [3:0] st, input logic [31:0] ex);
    bit got;
    got = 0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge iClk);
      if (oVramWr != 4'h0) begin got = 1; chk({nm, "_strobe"}, oVramWr, st); chk({nm, "_data"}, oVramWrData, ex); end
    end
    if (!got) chk({nm, "_timeout"}, 0, 1);
    step();
  endtask

  task automatic noSel(input string nm, input int n);
    int c;
    c = 0;
    repeat (n) begin @(negedge iClk); if (oSel) c++; end
    chk(nm, c, 0);
    step();
  endtask

  initial begin
    iRst = 1'b1; iAddr = '0; iWrData = '0; iWrMem = 0; iRdMem = 0; iWrIo = 0; iRdIo = 0;
    mdlReset();
    busyEnd = -10;
    repeat (3) step();
    iRst = 1'b0;
    @(negedge iClk);
    chk("rst_sel", oSel, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_rddata", oRdData, 0);
    chk("rst_wr", oVramWr, 0);
    chk("rst_wrdata", oVramWrData, 0);
    chk("rst_addr", oVramAddr, 0);
    step();
    chkEn = 1;
    preload(8'h10, 32'h115A3344);
    preload(8'h20, 32'hFF00FF00);
    preload(8'h21, 32'hFF00FF01);
    preload(8'h30, 32'hF0F0F0F0);
    preload(8'h40, 32'h000000FF);
    preload(8'h70, 32'h12345678);
    // read mode 0 plane select
    ioWr(12'h3CE, 8'h04); ioWr(12'h3CF, 8'h02);
    memRead(20'hA0010); waitSel("rm0_map2", 8'h5A);
    ioWr(12'h3CF, 8'h03);
    memRead(20'hA0010); waitSel("rm0_map3", 8'h11);
    // write mode 2 with bit mask
    memRead(20'hA0030); waitSel("lat_f0", 8'hF0);
    ioWr(12'h3CE, 8'h05); ioWr(12'h3CF, 8'h02);
    ioWr(12'h3CE, 8'h08); ioWr(12'h3CF, 8'h0F);
    memWrite(20'hA0050, 8'h05, 0); waitWr("wm2", 4'hF, 32'hF0FFF0FF);
    memRead(20'hA0050); waitSel("wm2_back", 8'hF0);
    // write mode 0, rotate and XOR, then set/reset
    memRead(20'hA0040); waitSel("lat_40", 8'h00);
    ioWr(12'h3CE, 8'h05); ioWr(12'h3CF, 8'h00);
    ioWr(12'h3CE, 8'h08); ioWr(12'h3CF, 8'hFF);
    ioWr(12'h3CE, 8'h03); ioWr(12'h3CF, 8'h19);
    memWrite(20'hA0060, 8'h03, 0); waitWr("wm0_rotxor", 4'hF, 32'h8181817E);
    ioWr(12'h3CE, 8'h00); ioWr(12'h3CF, 8'h0A);
    ioWr(12'h3CE, 8'h01); ioWr(12'h3CF, 8'h0C);
    memWrite(20'hA0061, 8'h03, 0); waitWr("wm0_sr", 4'hF, 32'hFF00817E);
    ioWr(12'h3CF, 8'h00);
    ioWr(12'h3CE, 8'h03); ioWr(12'h3CF, 8'h00);
    // read mode 1 colour compare
    ioWr(12'h3CE, 8'h05); ioWr(12'h3CF, 8'h08);
    ioWr(12'h3CE, 8'h02); ioWr(12'h3CF, 8'h0A);
    ioWr(12'h3CE, 8'h07); ioWr(12'h3CF, 8'h0F);
    memRead(20'hA0020); waitSel("rm1_match", 8'hFF);
    memRead(20'hA0021); waitSel("rm1_bit0", 8'hFE);
    ioWr(12'h3CF, 8'h00);
    memRead(20'hA0021); waitSel("rm1_nodc", 8'hFF);
    // map mask with write mode 1
    ioWr(12'h3C4, 8'h02); ioWr(12'h3C5, 8'h04);
    ioWr(12'h3CE, 8'h05); ioWr(12'h3CF, 8'h01);
    memWrite(20'hA0070, 8'hAA, 0); waitWr("wm1_mask", 4'b0100, 32'hFF00FF01);
    ioWr(12'h3CE, 8'h04); ioWr(12'h3CF, 8'h02);
    memRead(20'hA0070); waitSel("wm1_back", 8'h00);
    // busy drops and reset mid-read
    ioWr(12'h3CF, 8'h01);
    memRead(20'hA0010); memRead(20'hA0020); waitSel("drop_rd", 8'h33);
    noSel("drop_rd_none", 3);
    memRead(20'hA0010); memWrite(20'hA0090, 8'h55, 0); waitSel("drop_wr", 8'h33);
    memRead(20'hA0010); resetCyc(1); noSel("rst_midread", 5);
    memWrite(20'hA0080, 8'h3C, 1); waitWr("rdwr_both", 4'hF, 32'h3C3C3C3C);
    noSel("rdwr_nosel", 4);
    memRead(20'hB0010); memWrite(20'hB0010, 8'h77, 0); noSel("outwin", 4);
    // IO readback
    ioWr(12'h3CE, 8'h05); ioWr(12'h3CF, 8'h0A);
    ioRd(12'h3CF);
`ifdef VIDEO_GC_EGA_RDBACK_EN
    @(negedge iClk);
    chk("rdback_sel", oSel, 1);
    chk("rdback_data", oRdData, 8'h0A);
    step();
    ioRd(12'h3C4); step();
`else
    noSel("rdback_off", 3);
`endif
    repeat (4) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
